// File: rtl/cpu_pkg.sv
// Shared definitions for the CP0 exception sequencer: FSM encoding and interface defaults.
package cpu_pkg;

  localparam int          CAUSE_W_DEF     = 2;
  localparam logic [31:0] VECTOR_ADDR_DEF = 32'h0000_0004;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RET     = 3'd4
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins and its index is reported.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int CAUSE_W = 2
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [CAUSE_W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry/exit sequencer: edge-latched, masked, prioritised IRQs drive one-cycle
// CP0 EPC/Cause updates at an instruction boundary and fetch redirects on entry and ERET.
module exc_sequencer
  import cpu_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter int          CAUSE_W     = CAUSE_W_DEF,  // NUM_IRQ must not exceed 2**CAUSE_W
  parameter logic [31:0] VECTOR_ADDR = VECTOR_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               inst_bound,
  input  logic [31:0]        pc_next,
  input  logic               eret,
  input  logic [31:0]        epc_i,
  output logic               int_req,
  output logic               EPCWrite,
  output logic               CauseWrite,
  output logic [CAUSE_W-1:0] IntCause,
  output logic [31:0]        pc_o,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               in_service,
  output state_t             o_dbg_state
);

  state_t               r_state;
  state_t               w_next;
  logic [NUM_IRQ-1:0]   r_pending;
  logic [NUM_IRQ-1:0]   r_mask;
  logic [NUM_IRQ-1:0]   r_irq_q;
  logic [CAUSE_W-1:0]   r_id;
  logic [31:0]          r_pc;

  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_eligible;
  logic [NUM_IRQ-1:0]   w_clr;
  logic                 w_valid;
  logic [CAUSE_W-1:0]   w_id;
  logic                 w_take;

  assign w_rise      = irq & ~r_irq_q;
  assign w_eligible  = r_pending & r_mask;
  // A rise on the line being taken re-sets it, so the new request is not lost.
  assign w_clr       = w_take ? (NUM_IRQ'(1) << w_id) : '0;
  assign o_dbg_state = r_state;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio (
    .i_req   (w_eligible),
    .o_valid (w_valid),
    .o_idx   (w_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_mask    <= '1;
      r_irq_q   <= '0;
      r_id      <= '0;
      r_pc      <= '0;
    end else begin
      r_state   <= w_next;
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_wdata;
      if (w_take) begin
        r_id <= w_id;
        r_pc <= pc_next;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_take      = 1'b0;
    int_req     = 1'b0;
    EPCWrite    = 1'b0;
    CauseWrite  = 1'b0;
    IntCause    = '0;
    pc_o        = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    in_service  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (int_en && w_valid) w_next = ST_REQ;
      end
      ST_REQ: begin
        int_req = 1'b1;
        if (!int_en || !w_valid) begin
          w_next = ST_IDLE;
        end else if (inst_bound) begin
          w_take = 1'b1;
          w_next = ST_SAVE;
        end
      end
      ST_SAVE: begin
        EPCWrite    = 1'b1;
        CauseWrite  = 1'b1;
        IntCause    = r_id;
        pc_o        = r_pc;
        redirect    = 1'b1;
        redirect_pc = VECTOR_ADDR;
        w_next      = ST_SERVICE;
      end
      ST_SERVICE: begin
        in_service = 1'b1;
        if (eret) w_next = ST_RET;
      end
      ST_RET: begin
        redirect    = 1'b1;
        redirect_pc = epc_i;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
